// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
package imem_loader_pkg;

   // Loader states; encoding is fixed so debug taps read consistently.
   typedef enum logic [2:0] {
      HDR_LO = 3'd0,
      HDR_HI = 3'd1,
      DATA   = 3'd2,
      CSUM   = 3'd3,
      RUN    = 3'd4,
      ERR    = 3'd5
   } state_t;

   // Width of the frame's word-count field.
   localparam int CNT_W = 16;

   // Checksum algorithm selector: plain XOR over payload bytes.
   localparam logic [1:0] CSUM_XOR  = 2'd0;
   localparam logic [1:0] CSUM_ALGO = CSUM_XOR;

   // Byte order of payload words: byte 0 lands in bits 7:0.
   localparam logic BYTE_ORDER_LE = 1'b1;
   localparam logic BYTE_ORDER    = BYTE_ORDER_LE;

   // Fold one payload byte into the running checksum.
   function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
      logic [7:0] res;
      case (CSUM_ALGO)
         CSUM_XOR: res = acc ^ b;
         default:  res = acc ^ b;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles four consecutive bytes into a 32-bit word and flags it for one cycle.
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        clr,
   input  logic        byte_en,
   input  logic [7:0]  byte_data,
   output logic [1:0]  byte_idx,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [1:0]  idx_r;
   logic [31:0] shift_r;
   logic [31:0] word_r;
   logic        valid_r;
   logic [31:0] shift_next_s;

   // Shift the incoming byte in according to the configured byte order.
   always_comb begin
      shift_next_s = shift_r;
      if (BYTE_ORDER == BYTE_ORDER_LE) begin
         shift_next_s = {byte_data, shift_r[31:8]};
      end else begin
         shift_next_s = {shift_r[23:0], byte_data};
      end
   end

   // Byte counter, shift register and the one-cycle word strobe; the word holds when idle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         idx_r   <= 2'd0;
         shift_r <= 32'h0000_0000;
         word_r  <= 32'h0000_0000;
         valid_r <= 1'b0;
      end else if (clr) begin
         idx_r   <= 2'd0;
         shift_r <= 32'h0000_0000;
         valid_r <= 1'b0;
      end else begin
         valid_r <= 1'b0;
         if (byte_en) begin
            shift_r <= shift_next_s;
            idx_r   <= idx_r + 2'd1;
            if (idx_r == 2'd3) begin
               valid_r <= 1'b1;
               word_r  <= shift_next_s;
            end
         end
      end
   end

   assign byte_idx   = idx_r;
   assign word_valid = valid_r;
   assign word       = word_r;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a framed byte stream, writes instruction memory and
// releases the CPU only after the whole image passed its checksum.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 7
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   input  logic                  reload,
   output logic                  im_we,
   output logic [ADDR_WIDTH-1:0] im_addr,
   output logic [31:0]           im_wdata,
   output logic                  cpu_rstn,
   output logic                  load_done,
   output logic                  load_err
);

   localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(2 ** ADDR_WIDTH);

   state_t                state_r;
   state_t                state_s;
   logic [CNT_W-1:0]      cnt_r;
   logic [ADDR_WIDTH:0]   word_idx_r;
   logic [7:0]            acc_r;
   logic [ADDR_WIDTH-1:0] im_addr_r;
   logic                  cpu_rstn_r;
   logic                  load_done_r;
   logic                  load_err_r;

   logic                  in_ready_s;
   logic                  accept_s;
   logic                  pack_en_s;
   logic [CNT_W-1:0]      new_cnt_s;
   logic                  last_word_s;
   logic [1:0]            byte_idx_s;
   logic                  word_valid_s;
   logic [31:0]           word_s;

   assign accept_s    = in_valid && in_ready_s;
   assign pack_en_s   = accept_s && (state_r == DATA);
   assign new_cnt_s   = {in_data, cnt_r[7:0]};
   assign last_word_s = (({{(CNT_W-ADDR_WIDTH-1){1'b0}}, word_idx_r} + 16'd1) == cnt_r);

   byte_packer u_packer (
      .clk        (clk),
      .rstn       (rstn),
      .clr        (reload),
      .byte_en    (pack_en_s),
      .byte_data  (in_data),
      .byte_idx   (byte_idx_s),
      .word_valid (word_valid_s),
      .word       (word_s)
   );

   // Stream is open only in the receiving states and never while reload is pulsed.
   always_comb begin
      in_ready_s = 1'b0;
      case (state_r)
         HDR_LO, HDR_HI, DATA, CSUM: in_ready_s = !reload;
         default:                    in_ready_s = 1'b0;
      endcase
   end

   // Next-state decode of the frame parser; reload overrides everything.
   always_comb begin
      state_s = state_r;
      case (state_r)
         HDR_LO: begin
            if (accept_s) state_s = HDR_HI;
            else          state_s = HDR_LO;
         end
         HDR_HI: begin
            if (!accept_s)                     state_s = HDR_HI;
            else if (new_cnt_s == 16'd0)       state_s = CSUM;
            else if (new_cnt_s > MAX_WORDS)    state_s = ERR;
            else                               state_s = DATA;
         end
         DATA: begin
            if (accept_s && (byte_idx_s == 2'd3) && last_word_s) state_s = CSUM;
            else                                                 state_s = DATA;
         end
         CSUM: begin
            if (!accept_s)              state_s = CSUM;
            else if (in_data == acc_r)  state_s = RUN;
            else                        state_s = ERR;
         end
         RUN:     state_s = RUN;
         ERR:     state_s = ERR;
         default: state_s = ERR;
      endcase
      if (reload) begin
         state_s = HDR_LO;
      end else begin
         state_s = state_s;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_r <= HDR_LO;
      else       state_r <= state_s;
   end

   // Counters, checksum, write address and the registered status outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_r       <= 16'd0;
         word_idx_r  <= '0;
         acc_r       <= 8'h00;
         im_addr_r   <= '0;
         cpu_rstn_r  <= 1'b0;
         load_done_r <= 1'b0;
         load_err_r  <= 1'b0;
      end else if (reload) begin
         cnt_r       <= 16'd0;
         word_idx_r  <= '0;
         acc_r       <= 8'h00;
         cpu_rstn_r  <= 1'b0;
         load_done_r <= 1'b0;
         load_err_r  <= 1'b0;
      end else begin
         cpu_rstn_r  <= (state_r == RUN);
         load_done_r <= (state_r == RUN);
         load_err_r  <= (state_r == ERR);
         if (accept_s) begin
            case (state_r)
               HDR_LO: cnt_r[7:0]  <= in_data;
               HDR_HI: cnt_r[15:8] <= in_data;
               DATA: begin
                  acc_r <= csum_update(acc_r, in_data);
                  if (byte_idx_s == 2'd3) begin
                     im_addr_r  <= word_idx_r[ADDR_WIDTH-1:0];
                     word_idx_r <= word_idx_r + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign in_ready  = in_ready_s;
   assign im_we     = word_valid_s;
   assign im_addr   = im_addr_r;
   assign im_wdata  = word_s;
   assign cpu_rstn  = cpu_rstn_r;
   assign load_done = load_done_r;
   assign load_err  = load_err_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames, checksum, capacity, reload and reset.
module tb_imem_loader;

   logic        clk;
   logic        rstn;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        reload;
   logic        im_we;
   logic [6:0]  im_addr;
   logic [31:0] im_wdata;
   logic        cpu_rstn;
   logic        load_done;
   logic        load_err;

   int          total;
   int          bad;
   int          nwr;
   int          n0;
   logic [6:0]  last_addr;
   logic [31:0] mem [128];

   logic [7:0]  good_f [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                                8'h67, 8'h80, 8'h00, 8'h00};

   imem_loader #(.ADDR_WIDTH(7)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .reload    (reload),
      .im_we     (im_we),
      .im_addr   (im_addr),
      .im_wdata  (im_wdata),
      .cpu_rstn  (cpu_rstn),
      .load_done (load_done),
      .load_err  (load_err)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction-memory model fed by the write port.
   always @(negedge clk) begin
      if (im_we === 1'b1) begin
         mem[im_addr] = im_wdata;
         nwr          = nwr + 1;
         last_addr    = im_addr;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total = total + 1;
      if (got !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Present one byte from a negedge until it is taken, then idle for gap cycles.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      t        = 0;
      in_valid = 1'b1;
      in_data  = b;
      #1;
      while (!in_ready && t < 40) begin
         @(negedge clk);
         #1;
         t++;
      end
      if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_good(input logic [7:0] csum, input int gap);
      for (int i = 0; i < 10; i++) send_byte(good_f[i], gap);
      send_byte(csum, gap);
   endtask

   task automatic do_reload();
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      nwr      = 0;
      rstn     = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      reload   = 1'b0;
      repeat (2) @(negedge clk);

      // Reset values
      chk("rst_we",    32'(im_we),     32'd0);
      chk("rst_addr",  32'(im_addr),   32'd0);
      chk("rst_wdata", im_wdata,       32'h0000_0000);
      chk("rst_cpu",   32'(cpu_rstn),  32'd0);
      chk("rst_done",  32'(load_done), 32'd0);
      chk("rst_err",   32'(load_err),  32'd0);
      rstn = 1'b1;
      #1;
      chk("rst_ready", 32'(in_ready), 32'd1);
      @(negedge clk);

      // Good load with write and release latency
      n0 = nwr;
      for (int i = 0; i < 6; i++) send_byte(good_f[i], 0);
      chk("g_we_lat",   32'(im_we),   32'd1);
      chk("g_addr0",    32'(im_addr), 32'd0);
      chk("g_wdata0",   im_wdata,     32'h0010_0513);
      send_byte(good_f[6], 0);
      chk("g_we_pulse", 32'(im_we),   32'd0);
      chk("g_hold",     im_wdata,     32'h0010_0513);
      for (int i = 7; i < 10; i++) send_byte(good_f[i], 0);
      send_byte(8'hE1, 0);
      chk("g_cpu_early", 32'(cpu_rstn), 32'd0);
      @(negedge clk);
      chk("g_cpu",   32'(cpu_rstn),  32'd1);
      chk("g_done",  32'(load_done), 32'd1);
      chk("g_err",   32'(load_err),  32'd0);
      chk("g_ready", 32'(in_ready),  32'd0);
      chk("g_nwr",   32'(nwr - n0),  32'd2);
      chk("g_mem0",  mem[0],         32'h0010_0513);
      chk("g_mem1",  mem[1],         32'h0000_8067);
      do_reload();
      #1;
      chk("rl_done",  32'(load_done), 32'd0);
      chk("rl_cpu",   32'(cpu_rstn),  32'd0);
      chk("rl_ready", 32'(in_ready),  32'd1);
      @(negedge clk);

      // Bad checksum
      n0 = nwr;
      send_good(8'hE0, 0);
      @(negedge clk);
      chk("b_nwr",   32'(nwr - n0),  32'd2);
      chk("b_err",   32'(load_err),  32'd1);
      chk("b_cpu",   32'(cpu_rstn),  32'd0);
      chk("b_done",  32'(load_done), 32'd0);
      chk("b_ready", 32'(in_ready),  32'd0);
      do_reload();
      #1;
      chk("b_rl_err", 32'(load_err), 32'd0);
      @(negedge clk);

      // Empty image
      n0 = nwr;
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      @(negedge clk);
      chk("e_nwr",  32'(nwr - n0),  32'd0);
      chk("e_done", 32'(load_done), 32'd1);
      chk("e_cpu",  32'(cpu_rstn),  32'd1);
      do_reload();

      // Oversize count 129
      n0 = nwr;
      send_byte(8'h81, 0);
      send_byte(8'h00, 0);
      #1;
      chk("o_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("o_err",   32'(load_err), 32'd1);
      chk("o_nwr",   32'(nwr - n0), 32'd0);
      do_reload();

      // Full capacity: 128 words {A5, i, 3C, i}, checksum 00
      n0 = nwr;
      send_byte(8'h80, 0);
      send_byte(8'h00, 0);
      for (int i = 0; i < 128; i++) begin
         send_byte(8'(i), 0);
         send_byte(8'h3C, 0);
         send_byte(8'(i), 0);
         send_byte(8'hA5, 0);
      end
      send_byte(8'h00, 0);
      @(negedge clk);
      chk("c_nwr",   32'(nwr - n0),   32'd128);
      chk("c_last",  32'(last_addr),  32'd127);
      chk("c_mem0",  mem[0],          32'hA500_3C00);
      chk("c_mem64", mem[64],         32'hA540_3C40);
      chk("c_mem127", mem[127],       32'hA57F_3C7F);
      chk("c_done",  32'(load_done),  32'd1);
      chk("c_err",   32'(load_err),   32'd0);
      do_reload();

      // Backpressure: 3 idle cycles between bytes
      n0 = nwr;
      send_good(8'hE1, 3);
      chk("p_nwr",  32'(nwr - n0),  32'd2);
      chk("p_mem0", mem[0],         32'h0010_0513);
      chk("p_mem1", mem[1],         32'h0000_8067);
      chk("p_done", 32'(load_done), 32'd1);
      do_reload();

      // Abort after 6 payload bytes, reload alongside a byte, then a good frame
      n0 = nwr;
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      send_byte(8'hCC, 0);
      send_byte(8'hDD, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      chk("a_nwr",  32'(nwr - n0), 32'd1);
      chk("a_mem0", mem[0],        32'hDDCC_BBAA);
      reload   = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h05;
      #1;
      chk("a_rl_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      reload   = 1'b0;
      in_valid = 1'b0;
      n0 = nwr;
      send_good(8'hE1, 0);
      @(negedge clk);
      chk("a2_nwr",  32'(nwr - n0),  32'd2);
      chk("a2_mem0", mem[0],         32'h0010_0513);
      chk("a2_mem1", mem[1],         32'h0000_8067);
      chk("a2_done", 32'(load_done), 32'd1);
      do_reload();

      // Asynchronous reset while DATA is writing word 1 of a 3-word frame
      send_byte(8'h03, 0);
      for (int i = 1; i < 10; i++) send_byte(good_f[i], 0);
      chk("r_we_pre", 32'(im_we), 32'd1);
      rstn = 1'b0;
      #1;
      chk("r_we",    32'(im_we),    32'd0);
      chk("r_addr",  32'(im_addr),  32'd0);
      chk("r_wdata", im_wdata,      32'h0000_0000);
      chk("r_cpu",   32'(cpu_rstn), 32'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("r_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      n0 = nwr;
      send_good(8'hE1, 0);
      @(negedge clk);
      chk("r2_nwr",  32'(nwr - n0),  32'd2);
      chk("r2_mem1", mem[1],         32'h0000_8067);
      chk("r2_done", 32'(load_done), 32'd1);
      chk("r2_cpu",  32'(cpu_rstn),  32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader that sits directly upstream of the single-cycle CPU's instruction memory.
- Receives a framed little-endian byte stream on a valid/ready handshake and assembles 32-bit instruction words.
- Writes those words into the instruction ROM through a one-word write port.
- Holds the CPU in reset until a complete, checksum-verified image is loaded; replaces file-based ROM preload in hardware builds.

Parameters:
- ADDR_WIDTH, 7, instruction-memory word-address width; capacity MAX_WORDS = 2**ADDR_WIDTH = 128.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream payload.
- in_ready  out  1  loader accepts a byte this cycle.
- reload  in  1  single-cycle pulse; restarts loading.
- im_we  out  1  instruction-memory write enable; one-cycle pulse.
- im_addr  out  ADDR_WIDTH  word address (word index, not byte PC).
- im_wdata  out  32  instruction word.
- cpu_rstn  out  1  active-low reset to the CPU; registered.
- load_done  out  1  image loaded and verified.
- load_err  out  1  frame rejected.

Behaviour:
- Frame format: CNT_LO, CNT_HI (16-bit word count N, little-endian), then N*4 payload bytes (each word little-endian, byte 0 = bits 7:0), then CSUM.
- CSUM = XOR of all payload bytes. Header bytes are excluded.
- Byte transfer: a byte is accepted on a rising edge where in_valid && in_ready.
- in_ready = (state in {HDR_LO, HDR_HI, DATA, CSUM}) && !reload; it is combinational from state and reload.
- in_valid may drop at any time; gaps of any length are legal.
- States and transitions:
  - HDR_LO: accept byte → cnt[7:0] → HDR_HI.
  - HDR_HI: accept byte → cnt[15:8]. Then:
    - new cnt == 0 → CSUM;
    - new cnt > MAX_WORDS → ERR;
    - otherwise → DATA.
  - DATA:
    - byte_idx 0..3 shifts each byte into the word assembler; the XOR accumulator updates on every payload byte.
    - On the 4th byte, im_we = 1 for exactly the next cycle, with im_addr = word_idx and im_wdata = assembled word.
    - word_idx increments after each write. After word N-1 is written → CSUM.
  - CSUM: accept byte. Equal to accumulator → RUN; otherwise → ERR.
  - RUN: in_ready = 0, load_done = 1, cpu_rstn = 1 from the cycle after entry. Bytes are ignored.
  - ERR: in_ready = 0, load_err = 1, cpu_rstn = 0.
- Latency:
  - 4th byte accepted at edge k → im_we high during cycle k+1.
  - CSUM accepted at edge k → cpu_rstn and load_done high after edge k+1.
- Reset values (rstn low, immediate, asynchronous):
  - state = HDR_LO; cnt, word_idx, byte_idx, accumulator = 0.
  - im_we = 0, im_addr = 0, im_wdata = 0.
  - cpu_rstn = 0, load_done = 0, load_err = 0.
  - in_ready = 1 once rstn is released (state HDR_LO).
- reload (any state):
  - Next state = HDR_LO; all counters and the accumulator are cleared.
  - cpu_rstn = 0, load_done = 0, load_err = 0 after the edge.
  - A byte presented in the same cycle is not accepted.
  - A pending im_we from the previous cycle still completes.
- Reset mid-load: partial words are discarded. Instruction memory is not cleared; already-written words remain.
- Capacity boundary: N == MAX_WORDS is legal; the last write goes to im_addr = MAX_WORDS-1 with no wrap.
- im_wdata/im_addr hold their last values when im_we = 0.

Decomposition:
- Shared header package imem_loader_pkg holds:
  - state encoding localparams: HDR_LO=0, HDR_HI=1, DATA=2, CSUM=3, RUN=4, ERR=5;
  - the CSUM algorithm selector constant;
  - the byte-order constant.
- One natural sub-module: byte_packer. It performs the 4-byte little-endian shift/assemble, keeps byte_idx, and emits word_valid for one cycle with the word.

Test Plan:
- Good load: bytes 02 00 13 05 10 00 67 80 00 00 E1 → im_we pulses write addr 0 = 0x00100513 and addr 1 = 0x00008067; cpu_rstn and load_done go 1 one cycle after E1 is accepted; load_err = 0.
- Same frame with CSUM E0 → both writes occur; state ERR, load_err = 1, cpu_rstn stays 0, in_ready = 0.
- Empty image 00 00 00 → no im_we; RUN, load_done = 1. Oversize 81 00 (129 > 128) → ERR immediately after HDR_HI, no writes.
- Backpressure: good frame with in_valid low for 3 cycles between every byte → identical writes and result; no byte accepted while in_valid = 0.
- reload pulse after 6 payload bytes, then full good frame → first abort produces one write (addr 0), restart overwrites addr 0/1 correctly, load_done = 1. reload asserted alongside in_valid → that byte is not consumed.
- rstn low for 2 cycles mid-DATA → all outputs return to reset values asynchronously, in_ready = 1 after release; a good frame then loads normally.
